// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_t : fetch FSM states (RUN, DROP)
//   NOP_INSTR     : instruction word used for IF/ID bubbles
//   PC_STEP       : sequential PC increment
//   word_align    : clears the byte-offset bits of an address
package fetch_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      DROP = 1'b1
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_STEP   = 32'd4;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/adder.sv
// adder: plain W-bit adder, result wraps modulo 2^W.
//   a, b : operands
//   y    : a + b
module adder #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   assign y = a + b;

endmodule

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk, rst_n         : clock, synchronous active-low reset
//   hold               : keep current contents (stall)
//   clear              : load a bubble; wins over hold and load
//   instr_nxt          : fetched instruction word
//   pc_plus4_nxt       : PC+4 of that instruction
//   instr, pc_plus4,
//   valid              : register contents presented to decode
module if_id_reg
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hold,
   input  logic        clear,
   input  logic [31:0] instr_nxt,
   input  logic [31:0] pc_plus4_nxt,
   output logic [31:0] instr,
   output logic [31:0] pc_plus4,
   output logic        valid
);

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         instr    <= NOP_INSTR;
         pc_plus4 <= '0;
         valid    <= 1'b0;
      end else if (!hold) begin
         instr    <= instr_nxt;
         pc_plus4 <= pc_plus4_nxt;
         valid    <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage. Owns the PC and IF/ID register.
//   clk, rst_n      : clock, synchronous active-low reset
//   imem_req/addr   : fetch request, address = PC
//   imem_ready      : memory accepts request; imem_rdata valid same cycle
//   imem_rdata      : instruction word
//   stall           : hazard-unit stall, holds PC and IF/ID
//   redirect_d      : taken branch/jump resolved in decode
//   redirect_pc_d   : redirect target (low two bits ignored)
//   instr_d, pc_plus4_d, valid_d : IF/ID outputs to decode
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_d,
   input  logic [31:0] redirect_pc_d,
   output logic [31:0] instr_d,
   output logic [31:0] pc_plus4_d,
   output logic        valid_d
);

   logic [31:0]  pc;
   logic [31:0]  pc_plus4;
   logic [31:0]  redir_pc;
   logic [31:0]  target;
   logic         req_en;
   fetch_state_t state;
   logic         acc;
   logic         redir;
   logic         ifid_hold;
   logic         ifid_clr;

   // A ready with no request outstanding (first cycle after reset) is ignored.
   assign acc    = req_en & imem_ready;
   // Decode keeps redirect_d asserted across a stall, so it is acted on later.
   assign redir  = redirect_d & ~stall;
   assign target = word_align(redirect_pc_d);

   assign imem_req  = req_en;
   assign imem_addr = pc;

   adder #(.W(32)) u_pc_add (
      .a (pc),
      .b (PC_STEP),
      .y (pc_plus4)
   );

   // redir implies ~stall, so hold and clear never assert together. Only a
   // RUN-state accept without redirect loads a real instruction.
   assign ifid_hold = stall;
   assign ifid_clr  = ~stall & (redir | (state == DROP) | ~acc);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         req_en   <= 1'b0;
         state    <= RUN;
         redir_pc <= '0;
      end else begin
         req_en <= 1'b1;
         case (state)
            RUN: begin
               if (redir) begin
                  if (acc) begin
                     pc <= target;
                  end else begin
                     // Request still in flight: address must stay put, so
                     // park the target until the stale word is returned.
                     redir_pc <= target;
                     state    <= DROP;
                  end
               end else if (!stall && acc) begin
                  pc <= pc_plus4;
               end
            end
            DROP: begin
               if (acc) begin
                  // Stale word is discarded; a redirect arriving in the same
                  // cycle is newer than the parked one.
                  pc    <= redir ? target : redir_pc;
                  state <= RUN;
               end else if (redir) begin
                  redir_pc <= target;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   if_id_reg u_if_id (
      .clk          (clk),
      .rst_n        (rst_n),
      .hold         (ifid_hold),
      .clear        (ifid_clr),
      .instr_nxt    (imem_rdata),
      .pc_plus4_nxt (pc_plus4),
      .instr        (instr_d),
      .pc_plus4     (pc_plus4_d),
      .valid        (valid_d)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
// The instruction memory returns ~address, so every expected instruction is
// the complement of a hand-computed fetch address.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect_d;
   logic [31:0] redirect_pc_d;
   logic [31:0] instr_d;
   logic [31:0] pc_plus4_d;
   logic        valid_d;

   int npass  = 0;
   int ntotal = 0;

   always #5 clk = ~clk;

   assign imem_rdata = ~imem_addr;

   fetch_stage #(.RESET_PC(32'h0040_0000)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .stall         (stall),
      .redirect_d    (redirect_d),
      .redirect_pc_d (redirect_pc_d),
      .instr_d       (instr_d),
      .pc_plus4_d    (pc_plus4_d),
      .valid_d       (valid_d)
   );

   // Outputs are sampled and inputs driven 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; imem_ready = 1'b1; stall = 1'b0;
      redirect_d = 1'b0; redirect_pc_d = '0;
      tick(); tick();
      ntotal++; if (imem_req !== 1'b0) $display("FAIL reset_req got %0b exp 0", imem_req); else npass++;
      ntotal++; if (imem_addr !== 32'h0040_0000) $display("FAIL reset_addr got %h exp 00400000", imem_addr); else npass++;
      ntotal++; if (instr_d !== 32'h0) $display("FAIL reset_instr got %h exp 0", instr_d); else npass++;
      ntotal++; if (pc_plus4_d !== 32'h0) $display("FAIL reset_pc4 got %h exp 0", pc_plus4_d); else npass++;
      ntotal++; if (valid_d !== 1'b0) $display("FAIL reset_valid got %0b exp 0", valid_d); else npass++;
   endtask

   task automatic test_stream();
      logic [31:0] e;
      rst_n = 1'b1;
      tick();
      ntotal++; if (imem_req !== 1'b1) $display("FAIL first_req got %0b exp 1", imem_req); else npass++;
      ntotal++; if (valid_d !== 1'b0) $display("FAIL first_valid got %0b exp 0", valid_d); else npass++;
      for (int i = 1; i <= 3; i++) begin
         tick();
         e = 32'h0040_0000 + 32'(4 * i);
         ntotal++; if (valid_d !== 1'b1 || pc_plus4_d !== e) $display("FAIL stream_%0d got v=%0b pc4=%h exp v=1 pc4=%h", i, valid_d, pc_plus4_d, e); else npass++;
         ntotal++; if (instr_d !== ~(e - 32'd4)) $display("FAIL stream_instr_%0d got %h exp %h", i, instr_d, ~(e - 32'd4)); else npass++;
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         ntotal++; if (pc_plus4_d !== 32'h0040_000C || imem_addr !== 32'h0040_000C || instr_d !== ~32'h0040_0008)
            $display("FAIL stall_%0d got pc4=%h addr=%h instr=%h exp pc4=0040000c addr=0040000c instr=%h", i, pc_plus4_d, imem_addr, instr_d, ~32'h0040_0008);
         else npass++;
      end
      stall = 1'b0;
      tick();
      ntotal++; if (valid_d !== 1'b1 || pc_plus4_d !== 32'h0040_0010 || instr_d !== ~32'h0040_000C)
         $display("FAIL stall_resume got v=%0b pc4=%h instr=%h exp v=1 pc4=00400010 instr=%h", valid_d, pc_plus4_d, instr_d, ~32'h0040_000C);
      else npass++;
   endtask

   task automatic test_redirect();
      // Redirect under stall must be ignored until the stall lifts.
      stall = 1'b1; redirect_d = 1'b1; redirect_pc_d = 32'h0040_0103;
      tick();
      ntotal++; if (imem_addr !== 32'h0040_0010 || pc_plus4_d !== 32'h0040_0010 || valid_d !== 1'b1)
         $display("FAIL redir_stalled got addr=%h pc4=%h v=%0b exp addr=00400010 pc4=00400010 v=1", imem_addr, pc_plus4_d, valid_d);
      else npass++;
      stall = 1'b0;
      tick();
      ntotal++; if (valid_d !== 1'b0 || imem_addr !== 32'h0040_0100)
         $display("FAIL redir_bubble got v=%0b addr=%h exp v=0 addr=00400100", valid_d, imem_addr);
      else npass++;
      redirect_d = 1'b0;
      tick();
      ntotal++; if (valid_d !== 1'b1 || pc_plus4_d !== 32'h0040_0104 || instr_d !== ~32'h0040_0100)
         $display("FAIL redir_target got v=%0b pc4=%h instr=%h exp v=1 pc4=00400104 instr=%h", valid_d, pc_plus4_d, instr_d, ~32'h0040_0100);
      else npass++;
   endtask

   task automatic test_drop();
      imem_ready = 1'b0;
      tick();
      ntotal++; if (valid_d !== 1'b0 || imem_addr !== 32'h0040_0104)
         $display("FAIL wait_bubble got v=%0b addr=%h exp v=0 addr=00400104", valid_d, imem_addr);
      else npass++;
      redirect_d = 1'b1; redirect_pc_d = 32'h0040_0200;
      tick();
      ntotal++; if (valid_d !== 1'b0 || imem_addr !== 32'h0040_0104 || imem_req !== 1'b1)
         $display("FAIL drop_hold got v=%0b addr=%h req=%0b exp v=0 addr=00400104 req=1", valid_d, imem_addr, imem_req);
      else npass++;
      redirect_d = 1'b0; imem_ready = 1'b1;
      tick();
      ntotal++; if (valid_d !== 1'b0 || imem_addr !== 32'h0040_0200)
         $display("FAIL drop_exit got v=%0b addr=%h exp v=0 addr=00400200", valid_d, imem_addr);
      else npass++;
      tick();
      ntotal++; if (valid_d !== 1'b1 || pc_plus4_d !== 32'h0040_0204 || instr_d !== ~32'h0040_0200)
         $display("FAIL drop_target got v=%0b pc4=%h instr=%h exp v=1 pc4=00400204 instr=%h", valid_d, pc_plus4_d, instr_d, ~32'h0040_0200);
      else npass++;
   endtask

   task automatic test_drop_double();
      imem_ready = 1'b0; redirect_d = 1'b1; redirect_pc_d = 32'h0000_0100;
      tick();
      ntotal++; if (valid_d !== 1'b0 || imem_addr !== 32'h0040_0204)
         $display("FAIL dbl_first got v=%0b addr=%h exp v=0 addr=00400204", valid_d, imem_addr);
      else npass++;
      redirect_pc_d = 32'h0000_0300;
      tick();
      ntotal++; if (valid_d !== 1'b0 || imem_addr !== 32'h0040_0204)
         $display("FAIL dbl_second got v=%0b addr=%h exp v=0 addr=00400204", valid_d, imem_addr);
      else npass++;
      redirect_d = 1'b0; imem_ready = 1'b1;
      tick();
      ntotal++; if (imem_addr !== 32'h0000_0300 || valid_d !== 1'b0)
         $display("FAIL dbl_addr got addr=%h v=%0b exp addr=00000300 v=0", imem_addr, valid_d);
      else npass++;
      tick();
      ntotal++; if (valid_d !== 1'b1 || pc_plus4_d !== 32'h0000_0304)
         $display("FAIL dbl_resume got v=%0b pc4=%h exp v=1 pc4=00000304", valid_d, pc_plus4_d);
      else npass++;
   endtask

   task automatic test_reset_in_drop();
      imem_ready = 1'b0; redirect_d = 1'b1; redirect_pc_d = 32'h0000_0500;
      tick();
      redirect_d = 1'b0; stall = 1'b1;
      tick();
      rst_n = 1'b0;
      tick();
      ntotal++; if (imem_req !== 1'b0 || imem_addr !== 32'h0040_0000 || instr_d !== 32'h0 || pc_plus4_d !== 32'h0 || valid_d !== 1'b0)
         $display("FAIL rst_drop got req=%0b addr=%h instr=%h pc4=%h v=%0b exp req=0 addr=00400000 instr=0 pc4=0 v=0", imem_req, imem_addr, instr_d, pc_plus4_d, valid_d);
      else npass++;
      // Back in RUN: the first accept must advance, not jump to a parked target.
      rst_n = 1'b1; stall = 1'b0; imem_ready = 1'b1;
      tick();
      ntotal++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000)
         $display("FAIL rst_drop_req got req=%0b addr=%h exp req=1 addr=00400000", imem_req, imem_addr);
      else npass++;
      tick();
      ntotal++; if (valid_d !== 1'b1 || pc_plus4_d !== 32'h0040_0004 || imem_addr !== 32'h0040_0004)
         $display("FAIL rst_drop_run got v=%0b pc4=%h addr=%h exp v=1 pc4=00400004 addr=00400004", valid_d, pc_plus4_d, imem_addr);
      else npass++;
   endtask

   task automatic test_wrap();
      redirect_d = 1'b1; redirect_pc_d = 32'hFFFF_FFFF;
      tick();
      ntotal++; if (imem_addr !== 32'hFFFF_FFFC || valid_d !== 1'b0)
         $display("FAIL wrap_align got addr=%h v=%0b exp addr=fffffffc v=0", imem_addr, valid_d);
      else npass++;
      redirect_d = 1'b0;
      tick();
      ntotal++; if (valid_d !== 1'b1 || pc_plus4_d !== 32'h0 || instr_d !== 32'h0000_0003 || imem_addr !== 32'h0)
         $display("FAIL wrap_pc got v=%0b pc4=%h instr=%h addr=%h exp v=1 pc4=0 instr=00000003 addr=0", valid_d, pc_plus4_d, instr_d, imem_addr);
      else npass++;
      tick();
      ntotal++; if (valid_d !== 1'b1 || pc_plus4_d !== 32'h4 || instr_d !== 32'hFFFF_FFFF)
         $display("FAIL wrap_next got v=%0b pc4=%h instr=%h exp v=1 pc4=4 instr=ffffffff", valid_d, pc_plus4_d, instr_d);
      else npass++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_drop();
      test_drop_double();
      test_reset_in_drop();
      test_wrap();
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
